// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: register file with WB write-through, immediate
// extension, ALU-source decode, and the ID/EX pipeline register feeding the
// EX operand muxes.
module id_ex_operand_stage #(
  parameter int NB_INST = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_IMM  = 16,
  parameter int N_REGS  = 2**NB_ADDR
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_wb_write,
  input  logic [NB_ADDR-1:0] i_wb_addr,
  input  logic [NB_INST-1:0] i_wb_data,
  output logic               o_valid,
  output logic [NB_INST-1:0] o_rs_data,
  output logic [NB_INST-1:0] o_register_file_data,
  output logic [NB_INST-1:0] o_sign_extend,
  output logic               o_alu_src,
  output logic [NB_ADDR-1:0] o_rs_addr,
  output logic [NB_ADDR-1:0] o_rt_addr,
  output logic [NB_ADDR-1:0] o_rd_addr
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  logic [NB_INST-1:0] r_rf [N_REGS];

  logic               r_valid;
  logic [NB_INST-1:0] r_rs_data;
  logic [NB_INST-1:0] r_rt_data;
  logic [NB_INST-1:0] r_ext;
  logic               r_alu_src;
  logic [NB_ADDR-1:0] r_rs_addr;
  logic [NB_ADDR-1:0] r_rt_addr;
  logic [NB_ADDR-1:0] r_rd_addr;

  logic [5:0]         w_opcode;
  logic [NB_IMM-1:0]  w_imm;
  logic [NB_ADDR-1:0] w_rs_sel;
  logic [NB_ADDR-1:0] w_rt_sel;
  logic [NB_INST-1:0] w_rs_rd;
  logic [NB_INST-1:0] w_rt_rd;
  logic [NB_INST-1:0] w_ext;
  logic               w_alu_src;
  logic               w_wb_en;

  assign w_opcode = i_instruction[31:26];
  assign w_imm    = i_instruction[NB_IMM-1:0];
  assign w_wb_en  = i_wb_write && (i_wb_addr != '0);

  // While stalled the read ports follow the held addresses so that a WB
  // write landing during the stall is reflected in the held entry.
  assign w_rs_sel = i_stall ? r_rs_addr : i_instruction[25:21];
  assign w_rt_sel = i_stall ? r_rt_addr : i_instruction[20:16];

  // Register read: r0 is hardwired zero, same-cycle WB write bypasses the array.
  always_comb begin
    w_rs_rd = r_rf[w_rs_sel];
    w_rt_rd = r_rf[w_rt_sel];
    if (w_wb_en && (i_wb_addr == w_rs_sel)) w_rs_rd = i_wb_data;
    if (w_wb_en && (i_wb_addr == w_rt_sel)) w_rt_rd = i_wb_data;
    if (w_rs_sel == '0) w_rs_rd = '0;
    if (w_rt_sel == '0) w_rt_rd = '0;
  end

  // Decode ALU-source select and immediate extension from the opcode.
  always_comb begin
    w_alu_src = (w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ) ||
                (w_opcode == OP_BNE);
    case (w_opcode)
      OP_ANDI, OP_ORI, OP_XORI: w_ext = {{(NB_INST-NB_IMM){1'b0}}, w_imm};
      OP_LUI:                   w_ext = {w_imm, {(NB_INST-NB_IMM){1'b0}}};
      default:                  w_ext = {{(NB_INST-NB_IMM){w_imm[NB_IMM-1]}}, w_imm};
    endcase
  end

  // Register file write port; r0 writes are discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) r_rf[i] <= '0;
    end else if (w_wb_en) begin
      r_rf[i_wb_addr] <= i_wb_data;
    end
  end

  // ID/EX pipeline register: reset > flush > stall > capture/bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush || (!i_stall && !i_valid)) begin
      r_valid   <= 1'b0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_ext     <= '0;
      r_alu_src <= 1'b0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rd_addr <= '0;
    end else if (i_stall) begin
      r_rs_data <= w_rs_rd;
      r_rt_data <= w_rt_rd;
    end else begin
      r_valid   <= 1'b1;
      r_rs_data <= w_rs_rd;
      r_rt_data <= w_rt_rd;
      r_ext     <= w_ext;
      r_alu_src <= w_alu_src;
      r_rs_addr <= i_instruction[25:21];
      r_rt_addr <= i_instruction[20:16];
      r_rd_addr <= i_instruction[15:11];
    end
  end

  assign o_valid              = r_valid;
  assign o_rs_data            = r_rs_data;
  assign o_register_file_data = r_rt_data;
  assign o_sign_extend        = r_ext;
  assign o_alu_src            = r_alu_src;
  assign o_rs_addr            = r_rs_addr;
  assign o_rt_addr            = r_rt_addr;
  assign o_rd_addr            = r_rd_addr;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the stage.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, vld, stall, flush, wbw;
  logic [31:0] instr, wbd;
  logic [4:0]  wba;

  logic        o_valid, o_alu_src;
  logic [31:0] o_rs_data, o_rf_data, o_ext;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr;

  int total = 0;
  int bad   = 0;

  // model state: register file contents and expected ID/EX outputs
  logic [31:0] mrf [32];
  logic        e_v, e_src;
  logic [31:0] e_rs, e_rt, e_ext;
  logic [4:0]  e_rsa, e_rta, e_rda;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_instruction(instr),
    .i_stall(stall), .i_flush(flush), .i_wb_write(wbw), .i_wb_addr(wba),
    .i_wb_data(wbd), .o_valid(o_valid), .o_rs_data(o_rs_data),
    .o_register_file_data(o_rf_data), .o_sign_extend(o_ext),
    .o_alu_src(o_alu_src), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // what a reader of register a sees this cycle (r0 zero, WB write visible)
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wbw && wba == a) return wbd;
    return mrf[a];
  endfunction

  function automatic logic [112:0] got_vec();
    return {o_valid, o_rs_data, o_rf_data, o_ext, o_alu_src, o_rs_addr, o_rt_addr, o_rd_addr};
  endfunction

  function automatic logic [112:0] exp_vec();
    return {e_v, e_rs, e_rt, e_ext, e_src, e_rsa, e_rta, e_rda};
  endfunction

  task automatic quiet();
    rst = 0; vld = 0; stall = 0; flush = 0; wbw = 0; wba = 0; wbd = 0; instr = 0;
  endtask

  // one clock: predict the next stage contents, advance, then update model
  task automatic tick();
    logic        n_v, n_src;
    logic [31:0] n_rs, n_rt, n_ext;
    logic [4:0]  n_rsa, n_rta, n_rda;
    logic [15:0] imm;
    logic [5:0]  op;
    n_v = 0; n_src = 0; n_rs = 0; n_rt = 0; n_ext = 0; n_rsa = 0; n_rta = 0; n_rda = 0;
    op  = instr[31:26];
    imm = instr[15:0];
    if (rst || flush) begin
    end else if (stall) begin
      n_v = e_v; n_src = e_src; n_ext = e_ext;
      n_rsa = e_rsa; n_rta = e_rta; n_rda = e_rda;
      n_rs = mread(e_rsa); n_rt = mread(e_rta);
    end else if (vld) begin
      n_v   = 1;
      n_rsa = instr[25:21]; n_rta = instr[20:16]; n_rda = instr[15:11];
      n_rs  = mread(n_rsa); n_rt = mread(n_rta);
      n_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05);
      if (op == 6'h0C || op == 6'h0D || op == 6'h0E) n_ext = {16'h0, imm};
      else if (op == 6'h0F)                           n_ext = {imm, 16'h0};
      else                                            n_ext = {{16{imm[15]}}, imm};
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = 0;
    end else if (wbw && wba != 0) begin
      mrf[wba] = wbd;
    end
    e_v = n_v; e_src = n_src; e_rs = n_rs; e_rt = n_rt; e_ext = n_ext;
    e_rsa = n_rsa; e_rta = n_rta; e_rda = n_rda;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1; vld = 1; instr = mk(6'h00, 5'd1, 5'd2, 16'h1820);
    wbw = 1; wba = 5'd1; wbd = 32'hFFFF_0000;
    tick(); tick();
    total++;
    if (got_vec() !== 113'h0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", got_vec());
    end
    quiet();
    vld = 1; instr = mk(6'h00, 5'd5, 5'd6, {5'd3, 11'h020});
    tick();
    total++;
    if ({o_valid, o_rs_data, o_rf_data, o_alu_src, o_rd_addr} !== {1'b1, 32'h0, 32'h0, 1'b1, 5'd3}) begin
      bad++;
      $display("FAIL add_after_reset got v=%b rs=%h rt=%h src=%b rd=%0d want v=1 rs=0 rt=0 src=1 rd=3",
               o_valid, o_rs_data, o_rf_data, o_alu_src, o_rd_addr);
    end
  endtask

  task automatic test_regfile();
    quiet();
    wbw = 1; wba = 5'd5; wbd = 32'hDEAD_BEEF;
    tick();
    quiet();
    vld = 1; instr = mk(6'h00, 5'd5, 5'd5, 16'h2020);
    tick();
    total++;
    if ({o_rs_data, o_rf_data, o_alu_src} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1}) begin
      bad++; $display("FAIL rf_read got rs=%h rt=%h src=%b want deadbeef deadbeef 1",
                      o_rs_data, o_rf_data, o_alu_src);
    end
  endtask

  task automatic test_bypass();
    quiet();
    vld = 1; instr = mk(6'h08, 5'd7, 5'd8, 16'hFFFC);
    wbw = 1; wba = 5'd7; wbd = 32'h1234_5678;
    tick();
    total++;
    if ({o_rs_data, o_ext, o_alu_src} !== {32'h1234_5678, 32'hFFFF_FFFC, 1'b0}) begin
      bad++; $display("FAIL bypass got rs=%h ext=%h src=%b want 12345678 fffffffc 0",
                      o_rs_data, o_ext, o_alu_src);
    end
  endtask

  task automatic test_extend();
    quiet();
    vld = 1; instr = mk(6'h0D, 5'd1, 5'd2, 16'h8001);
    tick();
    total++;
    if ({o_ext, o_alu_src} !== {32'h0000_8001, 1'b0}) begin
      bad++; $display("FAIL ori_zext got ext=%h src=%b want 00008001 0", o_ext, o_alu_src);
    end
    instr = mk(6'h0F, 5'd0, 5'd3, 16'h1234);
    tick();
    total++;
    if (o_ext !== 32'h1234_0000) begin
      bad++; $display("FAIL lui got %h want 12340000", o_ext);
    end
    instr = mk(6'h04, 5'd1, 5'd2, 16'h8000);
    tick();
    total++;
    if ({o_ext, o_alu_src} !== {32'hFFFF_8000, 1'b1}) begin
      bad++; $display("FAIL beq got ext=%h src=%b want ffff8000 1", o_ext, o_alu_src);
    end
  endtask

  task automatic test_r0();
    quiet();
    wbw = 1; wba = 5'd0; wbd = 32'hFFFF_FFFF;
    tick();
    quiet();
    vld = 1; instr = mk(6'h00, 5'd0, 5'd0, 16'h0020);
    tick();
    total++;
    if ({o_rs_data, o_rf_data} !== 64'h0) begin
      bad++; $display("FAIL r0_write_dropped got rs=%h rt=%h want 0 0", o_rs_data, o_rf_data);
    end
    wbw = 1; wba = 5'd0; wbd = 32'hFFFF_FFFF;
    tick();
    total++;
    if ({o_rs_data, o_rf_data} !== 64'h0) begin
      bad++; $display("FAIL r0_no_bypass got rs=%h rt=%h want 0 0", o_rs_data, o_rf_data);
    end
  endtask

  task automatic test_stall_flush();
    quiet();
    vld = 1; instr = mk(6'h23, 5'd2, 5'd9, 16'h0010);
    tick();
    total++;
    if ({o_valid, o_alu_src, o_rt_addr, o_rf_data} !== {1'b1, 1'b0, 5'd9, 32'h0}) begin
      bad++; $display("FAIL lw_capture got v=%b src=%b rt=%0d data=%h want 1 0 9 0",
                      o_valid, o_alu_src, o_rt_addr, o_rf_data);
    end
    stall = 1; instr = mk(6'h00, 5'd3, 5'd4, 16'h2820);
    wbw = 1; wba = 5'd9; wbd = 32'hA5A5_A5A5;
    tick();
    total++;
    if ({o_valid, o_alu_src, o_rt_addr, o_ext, o_rf_data} !==
        {1'b1, 1'b0, 5'd9, 32'h0000_0010, 32'hA5A5_A5A5}) begin
      bad++; $display("FAIL stall_hold got v=%b src=%b rt=%0d ext=%h data=%h want 1 0 9 00000010 a5a5a5a5",
                      o_valid, o_alu_src, o_rt_addr, o_ext, o_rf_data);
    end
    wbw = 0; flush = 1;
    tick();
    total++;
    if (got_vec() !== 113'h0) begin
      bad++; $display("FAIL flush_over_stall got %h want 0", got_vec());
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    for (int n = 0; n < 500; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 11) == 0);
      stall = ($urandom_range(0, 3) == 0);
      vld   = ($urandom_range(0, 4) != 0);
      instr = {ops[$urandom_range(0, 9)], 26'($urandom)};
      wbw   = $urandom_range(0, 1);
      wba   = ($urandom_range(0, 2) == 0) ? instr[25:21] : 5'($urandom);
      wbd   = $urandom;
      tick();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cycle%0d got %h want %h", n, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    e_v = 0; e_src = 0; e_rs = 0; e_rt = 0; e_ext = 0; e_rsa = 0; e_rta = 0; e_rda = 0;
    quiet();
    test_reset();
    test_regfile();
    test_bypass();
    test_extend();
    test_r0();
    test_stall_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
